// File: rtl/uart_tx_phy_if.sv
// Byte handshake between the UART TX packet controller (master) and the
// serializer (slave). Accept is tx_valid && tx_ready at a rising clock edge.
interface uart_tx_phy_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx_phy.sv
// uart_tx_phy: UART byte serializer, 8N1 LSB first, CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit between data and stop).
module uart_tx_phy #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic         clk,
   input  logic         rst,
   uart_tx_phy_if.slave tx_if,
   output logic         txd,
   output logic         tx_busy
);
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
         $error("uart_tx_phy: CLKS_PER_BIT must be >= 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic             txd_reg, txd_next;
   logic             ready_reg, ready_next;
   logic             busy_reg, busy_next;
`ifdef UART_TX_PARITY_EN
   logic             parity_reg, parity_next;
`endif

   logic accept;
   logic bit_end;
   logic last_bit;

   assign accept   = tx_if.tx_valid & ready_reg;
   assign bit_end  = (baud_cnt_reg == CNT_MAX);
   assign last_bit = (bit_idx_reg == 3'd7);

   // State register; outputs are registered here too so they never glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         txd_reg      <= 1'b1;
         ready_reg    <= 1'b1;
         busy_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         shift_reg    <= shift_next;
         txd_reg      <= txd_next;
         ready_reg    <= ready_next;
         busy_reg     <= busy_next;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= parity_next;
`endif
      end
   end

   // Next-state and datapath logic.
   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = bit_end ? '0 : baud_cnt_reg + CNT_W'(1);
      bit_idx_next  = bit_idx_reg;
      shift_next    = shift_reg;
`ifdef UART_TX_PARITY_EN
      parity_next   = parity_reg;
`endif
      case (state_reg)
         S_IDLE: begin
            baud_cnt_next = '0;
            if (accept) begin
               shift_next = tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
               parity_next = ^tx_if.tx_data;
`endif
               state_next = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_next   = S_DATA;
               bit_idx_next = 3'd0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_next = {1'b0, shift_reg[7:1]};
               if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                  state_next = S_PARITY;
`else
                  state_next = S_STOP;
`endif
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next    = S_IDLE;
            baud_cnt_next = '0;
         end
      endcase
   end

   // Output logic: next values of the registered line and handshake outputs.
   always_comb begin
      txd_next   = txd_reg;
      ready_next = ready_reg;
      busy_next  = busy_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               txd_next   = 1'b0;
               ready_next = 1'b0;
               busy_next  = 1'b1;
            end else begin
               txd_next   = 1'b1;
               ready_next = 1'b1;
               busy_next  = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               txd_next = shift_reg[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                  txd_next = parity_reg;
`else
                  txd_next = 1'b1;
`endif
               end else begin
                  txd_next = shift_reg[1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               txd_next = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               txd_next   = 1'b1;
               ready_next = 1'b1;
               busy_next  = 1'b0;
            end
         end
         default: begin
            txd_next   = 1'b1;
            ready_next = 1'b1;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign txd            = txd_reg;
   assign tx_busy        = busy_reg;
   assign tx_if.tx_ready = ready_reg;

endmodule

// File: tb/tb_uart_tx_phy.sv
// Scoreboard bench for uart_tx_phy: accepted bytes are queued, a line monitor
// rebuilds each frame from the byte value and checks it cycle by cycle.
module tb_uart_tx_phy;
`ifdef UART_TX_PARITY_EN
   localparam int CPB   = 3;
   localparam int NBITS = 11;
`else
   localparam int CPB   = 4;
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = CPB * NBITS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic txd;
   logic tx_busy;

   uart_tx_phy_if tx_if ();

   uart_tx_phy #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_if   (tx_if),
      .txd     (txd),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];
   int start_q[$];
   int acc_cnt = 0;
   bit mon_busy = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference frame: start 0, data LSB first, optional even parity, stop 1.
   function automatic bit [NBITS-1:0] frame_bits(input logic [7:0] b);
      bit [NBITS-1:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
      f[9] = ($countones(b) % 2) == 1;
`endif
      f[NBITS-1] = 1'b1;
      return f;
   endfunction

   // Scoreboard push: an accept happens on the next edge when valid and ready are both high.
   always @(negedge clk) begin
      if (!rst && tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
         exp_q.push_back(tx_if.tx_data);
         acc_cnt++;
      end
   end

   task automatic run_frame(input logic [7:0] b);
      bit [NBITS-1:0] fb;
      bit hs_ok;
      logic got_v;
      fb = frame_bits(b);
      hs_ok = 1'b1;
      for (int k = 0; k < NBITS; k++) begin
         got_v = fb[k];
         for (int s = 0; s < CPB; s++) begin
            if (!(k == 0 && s == 0)) @(negedge clk);
            if (rst) begin
               $display("frame %02h abandoned by reset after bit %0d", b, k);
               return;
            end
            if (txd !== fb[k] && got_v === fb[k]) got_v = txd;
            if (tx_if.tx_ready !== 1'b0 || tx_busy !== 1'b1) hs_ok = 1'b0;
         end
         chk($sformatf("frame_%02h_bit%0d", b, k), 32'(got_v), 32'(fb[k]));
      end
      chk($sformatf("frame_%02h_ready_low", b), 32'(hs_ok), 32'd1);
      @(negedge clk);
      if (rst) return;
      chk($sformatf("frame_%02h_ready_rise", b), 32'({txd, tx_if.tx_ready, tx_busy}), 32'b110);
      $display("frame %02h: %0d bit periods of %0d cycles checked", b, NBITS, CPB);
   endtask

   initial begin : monitor
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (txd === 1'b0) begin
               start_q.push_back(cyc);
               mon_busy = 1'b1;
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", 32'd1, 32'd0);
                  repeat (FRAME_CYC) @(negedge clk);
               end else begin
                  b = exp_q.pop_front();
                  run_frame(b);
               end
               mon_busy = 1'b0;
            end else begin
               chk("idle_status", 32'({txd, tx_if.tx_ready, tx_busy}), 32'b110);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit keep_valid);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      tx_if.tx_data  = b;
      tx_if.tx_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_if.tx_ready === 1'b1 && !rst) break;
         n++;
         if (n > 4 * FRAME_CYC) begin
            chk("accept_timeout", 32'd0, 32'd1);
            tx_if.tx_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      if (!keep_valid) tx_if.tx_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((exp_q.size() != 0 || mon_busy) && n < 3 * FRAME_CYC);
      chk(name, 32'(exp_q.size() == 0 && !mon_busy), 32'd1);
   endtask

   initial begin : stimulus
      int a0;
      bit ok;
      logic [7:0] rb;
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = 8'h00;

      repeat (3) @(negedge clk);
      chk("reset_state", 32'({txd, tx_if.tx_ready, tx_busy}), 32'b110);
      @(posedge clk);
      #1 rst = 1'b0;

      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if ({txd, tx_if.tx_ready, tx_busy} !== 3'b110) ok = 1'b0;
      end
      chk("idle20", 32'(ok), 32'd1);

      send_byte(8'h55, 1'b0);
      wait_done("done_55");

      start_q.delete();
      a0 = acc_cnt;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h3C, 1'b0);
      wait_done("done_b2b");
      chk("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
      chk("b2b_frames", 32'(start_q.size()), 32'd2);
      if (start_q.size() == 2)
         chk("b2b_spacing", 32'(start_q[1] - start_q[0]), 32'(FRAME_CYC + 1));

      a0 = acc_cnt;
      send_byte(8'h00, 1'b0);
      repeat (2 * CPB + 1) @(posedge clk);
      #1 tx_if.tx_data = 8'hFF;
      wait_done("done_midframe");
      repeat (CPB) @(negedge clk);
      chk("midframe_accepts", 32'(acc_cnt - a0), 32'd1);

      send_byte(8'hC3, 1'b0);
      repeat (12) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("rst_async", 32'({txd, tx_if.tx_ready, tx_busy}), 32'b110);
      @(negedge clk);
      chk("rst_held", 32'({txd, tx_if.tx_ready, tx_busy}), 32'b110);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_queue_clear", 32'(exp_q.size()), 32'd0);
      send_byte(8'h81, 1'b0);
      wait_done("done_81");

      send_byte(8'h07, 1'b0);
      wait_done("done_07");
      send_byte(8'h03, 1'b0);
      wait_done("done_03");

      for (int i = 0; i < 40; i++) begin
         rb = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send_byte(rb, bit'($urandom_range(0, 1)));
      end
      tx_if.tx_valid = 1'b0;
      wait_done("done_random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_phy.md
# uart_tx_phy

Byte-level UART serializer that sits directly downstream of the UART TX packet controller. It accepts one byte per valid/ready handshake and shifts it out on the serial line as an 8N1 frame, LSB first, at a fixed integer clocks-per-bit rate. It owns `tx_ready` back to the controller, so it sets the packet byte pacing.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: system clocks per serial bit (100 MHz / 115200). Must be ≥ 2; elaboration error otherwise.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `tx_data`  in  8  byte to send; sampled only on accept.
- `tx_valid`  in  1  byte on `tx_data` is valid.
- `tx_ready`  out  1  registered; high only in IDLE. Accept = `tx_valid && tx_ready` at a rising edge.
- `txd`  out  1  serial line; idle level 1.
- `tx_busy`  out  1  registered; high from the accept edge until the frame ends.

## Operation
- Reset values, applied asynchronously and held while `rst` is high:
  - `txd`=1, `tx_ready`=1, `tx_busy`=0.
  - State IDLE; baud counter 0; bit index 0; shift register 0.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE:
  - `txd`=1 and `tx_ready`=1.
  - On accept: latch `tx_data` into the shift register, clear the baud counter, clear `tx_ready`, set `tx_busy`, drive `txd`=0, go to START.
  - `tx_valid` without `tx_ready` is ignored. The upstream controller holds `tx_valid` high across a packet; that is legal.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0 to CLKS_PER_BIT-1 within each bit, then wraps to 0 and advances the bit.
- START: after CLKS_PER_BIT cycles, `txd` = shift[0] and the FSM goes to DATA with bit index 0.
- DATA:
  - At the end of each bit period, shift right by one and drive the next LSB on `txd`.
  - After bit index 7 completes, go to PARITY if compiled in, otherwise to STOP with `txd`=1.
- STOP:
  - `txd`=1 for CLKS_PER_BIT cycles.
  - At the end: go to IDLE, set `tx_ready`=1, clear `tx_busy`.
- `tx_data` changes while not ready have no effect on the frame in flight.
- Reset mid-frame: `txd` returns to 1 immediately. The partial frame is abandoned and not resumed; the receiver sees a framing error, which is acceptable.

## Timing
- Latency: `txd` falls on the same edge that accepts the byte.
- Frame length, from the accept edge to the edge where `tx_ready` returns high:
  - 10×CLKS_PER_BIT cycles.
  - 11×CLKS_PER_BIT cycles with parity.
- `tx_ready` is low for exactly that frame length after each accept. It is never high in the cycle after an accept, so the controller's next-byte load cannot double-count.
- Back-to-back bytes: the earliest next accept is the edge after `tx_ready` rises. The inter-frame stop-level time is therefore CLKS_PER_BIT+1 cycles.
- Every bit, including start and stop, is exactly CLKS_PER_BIT cycles wide, with no drift across frames.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - `txd` = XOR of the 8 latched data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame is 8E1, 11 bit periods.
- Not defined: no PARITY state; frame is 8N1, 10 bit periods.
- The port list is identical in both builds.

## Test plan
All scenarios use CLKS_PER_BIT=4 except the last.
- Reset, then idle 20 cycles:
  - `txd`=1, `tx_ready`=1, `tx_busy`=0 throughout.
- Send 0x55:
  - `txd` is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - `tx_ready` rises 40 cycles after the accept edge.
- Hold `tx_valid` high with 0xA5, then 0x3C applied after the first accept:
  - Two frames: data bits 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0.
  - Stop-level gap of 5 cycles between frames.
  - Exactly two accepts.
- Change `tx_data` to 0xFF mid-frame of a 0x00 send:
  - All 8 data bits are 0; no extra accept occurs.
- Assert `rst` at cycle 13 of a frame:
  - `txd`=1 and `tx_ready`=1 immediately.
  - A new 0x81 sent after release produces a clean frame.
- `UART_TX_PARITY_EN`, CLKS_PER_BIT=3:
  - Send 0x07: parity bit 1, frame 33 cycles.
  - Send 0x03: parity bit 0.
